shared_port_scheduler: RTL and testbench

Round-robin scheduler that shares one single-ported pipeline resource (memory or register-file write port) among `NUM_REQ` requesters on a transaction basis. A grant is held for a whole variable-length transaction, bounded by a hold limit that forces preemption when other requesters are waiting. The block sits between the pipeline stages and the shared port. Its per-requester stall outputs feed the global stall logic.

---
 rtl/shared_port_scheduler_if.sv | 24 ++
 rtl/shared_port_scheduler.sv | 129 ++++++++++++
 tb/tb_shared_port_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_port_scheduler_if.sv
// Requester-side bundle of the shared port scheduler: request/done levels in,
// registered grant information and per-requester stalls out.
interface shared_port_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] grant;
   logic               grant_valid;
   logic [ID_W-1:0]    grant_id;
   logic               preempt;
   logic [NUM_REQ-1:0] stall;

   modport master (
      output req, done,
      input  grant, grant_valid, grant_id, preempt, stall
   );

   modport slave (
      input  req, done,
      output grant, grant_valid, grant_id, preempt, stall
   );
endinterface

// File: rtl/shared_port_scheduler.sv
// Round-robin, transaction-based owner selection for one shared pipeline port.
// A grant lasts until done/abandon, or until the hold limit when others wait.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no owner; arbitrate among req, winner granted at the next edge
//   S_GRANT | owner grant_id holds the port; hold_cnt counts owned cycles
//   S_GAP   | one turnaround cycle with no grant; req is not sampled
module shared_port_scheduler #(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 8,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   shared_port_scheduler_if.slave bus
);
   localparam int HC_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   state_t             r_state, w_state_nxt;
   logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
   logic               r_grant_valid, w_grant_valid_nxt;
   logic [ID_W-1:0]    r_grant_id, w_grant_id_nxt;
   logic [ID_W-1:0]    r_last_id, w_last_id_nxt;
   logic [HC_W-1:0]    r_hold_cnt, w_hold_cnt_nxt;
   logic               r_preempt, w_preempt_nxt;

   logic               w_found;
   logic [ID_W-1:0]    w_idx;
   logic [ID_W-1:0]    w_win_id;
   logic               w_owner_done;
   logic               w_owner_req;
   logic               w_waiting;
   logic               w_hold_hit;

   // Round-robin search: first set req bit above last_id, wrapping around.
   always_comb begin
      w_found  = 1'b0;
      w_idx    = r_last_id;
      w_win_id = r_last_id;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = ID_W'((int'(r_last_id) + i) % NUM_REQ);
         if (!w_found && bus.req[w_idx]) begin
            w_found  = 1'b1;
            w_win_id = w_idx;
         end
      end
   end

   assign w_owner_done = bus.done[r_grant_id];
   assign w_owner_req  = bus.req[r_grant_id];
   assign w_waiting    = |(bus.req & ~r_grant);
   assign w_hold_hit   = (r_hold_cnt == HC_W'(MAX_HOLD));

   // Next-state and registered-output decode.
   always_comb begin
      w_state_nxt       = r_state;
      w_grant_nxt       = r_grant;
      w_grant_valid_nxt = r_grant_valid;
      w_grant_id_nxt    = r_grant_id;
      w_last_id_nxt     = r_last_id;
      w_hold_cnt_nxt    = r_hold_cnt;
      w_preempt_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_grant_nxt           = '0;
               w_grant_nxt[w_win_id] = 1'b1;
               w_grant_valid_nxt     = 1'b1;
               w_grant_id_nxt        = w_win_id;
               w_last_id_nxt         = w_win_id;
               w_hold_cnt_nxt        = HC_W'(1);
               w_state_nxt           = S_GRANT;
            end
         end
         S_GRANT: begin
            if (w_owner_done || !w_owner_req || (w_hold_hit && w_waiting)) begin
               w_grant_nxt       = '0;
               w_grant_valid_nxt = 1'b0;
               w_hold_cnt_nxt    = '0;
               w_state_nxt       = S_GAP;
               // Completion or abandon on the same edge wins over preemption.
               w_preempt_nxt     = w_owner_req && !w_owner_done;
            end else if (!w_hold_hit) begin
               w_hold_cnt_nxt = r_hold_cnt + HC_W'(1);
            end
         end
         S_GAP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt       = S_IDLE;
            w_grant_nxt       = '0;
            w_grant_valid_nxt = 1'b0;
            w_hold_cnt_nxt    = '0;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_grant       <= '0;
         r_grant_valid <= 1'b0;
         r_grant_id    <= '0;
         r_last_id     <= ID_W'(NUM_REQ - 1);
         r_hold_cnt    <= '0;
         r_preempt     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_grant_valid <= w_grant_valid_nxt;
         r_grant_id    <= w_grant_id_nxt;
         r_last_id     <= w_last_id_nxt;
         r_hold_cnt    <= w_hold_cnt_nxt;
         r_preempt     <= w_preempt_nxt;
      end
   end

   assign bus.grant       = r_grant;
   assign bus.grant_valid = r_grant_valid;
   assign bus.grant_id    = r_grant_id;
   assign bus.preempt     = r_preempt;
   assign bus.stall       = bus.req & ~r_grant;

endmodule

// File: tb/tb_shared_port_scheduler.sv
// Scoreboard bench for shared_port_scheduler (NUM_REQ=4, MAX_HOLD=8).
module tb_shared_port_scheduler;
   logic clk;
   logic reset_n;

   shared_port_scheduler_if #(.NUM_REQ(4)) bus ();

   shared_port_scheduler #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [1:0] id;
      logic       p;
   } exp_t;

   exp_t  q[$];
   exp_t  m_e;
   int    checks = 0;
   int    errors = 0;
   string cur_test = "none";

   // Monitor: each edge that follows a drive pops one expectation.
   always @(posedge clk) begin
      #1;
      if (q.size() != 0) begin
         m_e = q.pop_front();
         checks++;
         if (bus.grant !== m_e.g) begin
            errors++;
            $display("FAIL %s grant: got %b expected %b at %0t", cur_test, bus.grant, m_e.g, $time);
         end
         checks++;
         if (bus.grant_valid !== (m_e.g != 4'b0)) begin
            errors++;
            $display("FAIL %s grant_valid: got %b expected %b at %0t", cur_test, bus.grant_valid, (m_e.g != 4'b0), $time);
         end
         checks++;
         if (bus.grant_id !== m_e.id) begin
            errors++;
            $display("FAIL %s grant_id: got %0d expected %0d at %0t", cur_test, bus.grant_id, m_e.id, $time);
         end
         checks++;
         if (bus.preempt !== m_e.p) begin
            errors++;
            $display("FAIL %s preempt: got %b expected %b at %0t", cur_test, bus.preempt, m_e.p, $time);
         end
         checks++;
         if (bus.stall !== (m_e.r & ~m_e.g)) begin
            errors++;
            $display("FAIL %s stall: got %b expected %b at %0t", cur_test, bus.stall, (m_e.r & ~m_e.g), $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Drive req/done for one edge and record the outputs expected after it.
   task automatic drive(input logic [3:0] r, input logic [3:0] d, input logic [3:0] eg,
                        input logic [1:0] eid, input logic ep);
      exp_t e;
      @(posedge clk);
      #2;
      bus.req  = r;
      bus.done = d;
      e.r  = r;
      e.g  = eg;
      e.id = eid;
      e.p  = ep;
      q.push_back(e);
   endtask

   task automatic settle();
      @(posedge clk);
      #3;
   endtask

   task automatic apply_reset();
      reset_n  = 1'b0;
      bus.req  = 4'b0;
      bus.done = 4'b0;
      settle();
      settle();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      cur_test = "reset";
      reset_n  = 1'b0;
      bus.req  = 4'b0101;
      bus.done = 4'b0;
      #7;
      checks++;
      if (bus.grant !== 4'b0) begin errors++; $display("FAIL reset grant: got %b expected 0000", bus.grant); end
      checks++;
      if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset grant_valid: got %b expected 0", bus.grant_valid); end
      checks++;
      if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset grant_id: got %0d expected 0", bus.grant_id); end
      checks++;
      if (bus.preempt !== 1'b0) begin errors++; $display("FAIL reset preempt: got %b expected 0", bus.preempt); end
      checks++;
      if (bus.stall !== 4'b0101) begin errors++; $display("FAIL reset stall: got %b expected 0101", bus.stall); end
      settle();
   endtask

   task automatic test_single();
      cur_test = "single";
      apply_reset();
      drive(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
      drive(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
      drive(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
      drive(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0);
      drive(4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0);
      drive(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
      drive(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0);
      drive(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
      settle();
   endtask

   task automatic test_round_robin();
      logic [3:0] oh;
      logic [1:0] o;
      cur_test = "round_robin";
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         o  = 2'(k % 4);
         oh = 4'b0001 << o;
         drive(4'b1111, 4'b0000, oh,      o, 1'b0);
         drive(4'b1111, oh,      4'b0000, o, 1'b0);
         drive(4'b1111, 4'b0000, 4'b0000, o, 1'b0);
      end
      drive(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
      settle();
   endtask

   task automatic test_preempt();
      cur_test = "preempt";
      apply_reset();
      repeat (8) drive(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0);
      drive(4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b1);
      drive(4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0);
      repeat (8) drive(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0);
      drive(4'b0011, 4'b0000, 4'b0000, 2'd1, 1'b1);
      drive(4'b0011, 4'b0000, 4'b0000, 2'd1, 1'b0);
      drive(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0);
      drive(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
      settle();
   endtask

   task automatic test_uncontested();
      cur_test = "uncontested";
      apply_reset();
      repeat (20) drive(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
      // Saturated hold counter: a newcomer forces preemption on the very next edge.
      drive(4'b0110, 4'b0000, 4'b0000, 2'd2, 1'b1);
      drive(4'b0110, 4'b0000, 4'b0000, 2'd2, 1'b0);
      drive(4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b0);
      drive(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
      settle();
   endtask

   task automatic test_coincident();
      cur_test = "coincident";
      apply_reset();
      repeat (8) drive(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0);
      drive(4'b0011, 4'b0001, 4'b0000, 2'd0, 1'b0);
      drive(4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0);
      drive(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0);
      drive(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0);
      drive(4'b0001, 4'b0000, 4'b0000, 2'd1, 1'b0);
      drive(4'b0001, 4'b0000, 4'b0000, 2'd1, 1'b0);
      drive(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
      drive(4'b0001, 4'b1110, 4'b0001, 2'd0, 1'b0);
      drive(4'b0001, 4'b0010, 4'b0001, 2'd0, 1'b0);
      drive(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0);
      drive(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0);
      drive(4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b0);
      drive(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
      drive(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
      settle();
   endtask

   task automatic test_reset_mid();
      cur_test = "reset_mid";
      apply_reset();
      repeat (8) drive(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b0);
      drive(4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b1);
      settle();
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.preempt !== 1'b0) begin errors++; $display("FAIL reset_mid preempt_clear: got %b expected 0", bus.preempt); end

      apply_reset();
      drive(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
      drive(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
      settle();
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.grant !== 4'b0) begin errors++; $display("FAIL reset_mid grant: got %b expected 0000", bus.grant); end
      checks++;
      if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_mid grant_valid: got %b expected 0", bus.grant_valid); end
      checks++;
      if (bus.preempt !== 1'b0) begin errors++; $display("FAIL reset_mid preempt: got %b expected 0", bus.preempt); end
      checks++;
      if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_mid grant_id: got %0d expected 0", bus.grant_id); end
      bus.req = 4'b1111;
      #10;
      reset_n = 1'b1;
      settle();
      checks++;
      if (bus.grant !== 4'b0001) begin errors++; $display("FAIL reset_mid first_grant: got %b expected 0001", bus.grant); end
      checks++;
      if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_mid first_id: got %0d expected 0", bus.grant_id); end
      checks++;
      if (bus.grant_valid !== 1'b1) begin errors++; $display("FAIL reset_mid first_valid: got %b expected 1", bus.grant_valid); end
      bus.req = 4'b0000;
      settle();
   endtask

   initial begin
      reset_n  = 1'b0;
      bus.req  = 4'b0;
      bus.done = 4'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_preempt();
      test_uncontested();
      test_coincident();
      test_reset_mid();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
